// File: rtl/sop_sweep_ctrl.sv
// sop_sweep_ctrl: sweeps pqrs 0000..1111 into a 4-input SOP block, captures tt and checks it against EXPECTED.
// Optional SOP_SWEEP_FAILCAP_EN adds fail_valid/fail_idx reporting of the first mismatching vector.
module sop_sweep_ctrl #(
  parameter int          HOLD_CYCLES = 20,
  parameter logic [15:0] EXPECTED    = 16'h4644
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        tt,
  output logic        pp,
  output logic        qq,
  output logic        rr,
  output logic        ss,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out
`ifdef SOP_SWEEP_FAILCAP_EN
  ,
  output logic        fail_valid,
  output logic [3:0]  fail_idx
`endif
);
  localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0]    idx;
  logic [HW-1:0] hold_cnt;
  logic          go, smp, last;
  logic [15:0]   cap;
  always_comb begin
    go        = (state == IDLE) && start && !abort;
    smp       = (state == DRIVE) && !abort && (hold_cnt == HW'(HOLD_CYCLES - 1));
    last      = smp && (idx == 4'd15);
    cap       = table_out;
    cap[idx]  = tt;
    state_nxt = abort ? IDLE : go ? DRIVE : last ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // pass is decided on the final sample edge so it is already valid during DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      hold_cnt  <= '0;
      table_out <= '0;
      pass      <= 1'b0;
`ifdef SOP_SWEEP_FAILCAP_EN
      fail_valid <= 1'b0;
      fail_idx   <= '0;
`endif
    end else if (go) begin
      idx       <= '0;
      hold_cnt  <= '0;
      table_out <= '0;
      pass      <= 1'b0;
`ifdef SOP_SWEEP_FAILCAP_EN
      fail_valid <= 1'b0;
      fail_idx   <= '0;
`endif
    end else if (abort && state != IDLE) begin
      pass <= 1'b0;
    end else if (state == DRIVE) begin
      hold_cnt <= smp ? '0 : HW'(hold_cnt + 1'b1);
      if (smp) begin
        table_out <= cap;
        idx       <= idx + {3'd0, !last};
        if (last) pass <= (cap == EXPECTED);
`ifdef SOP_SWEEP_FAILCAP_EN
        if (!fail_valid && tt != EXPECTED[idx]) begin
          fail_valid <= 1'b1;
          fail_idx   <= idx;
        end
`endif
      end
    end
  end
  assign {pp, qq, rr, ss} = (state == DRIVE) ? idx : 4'd0;
  assign busy = (state == DRIVE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// tb_sop_sweep_ctrl: directed checks of sop_sweep_ctrl against a behavioural SOP model (HOLD 20 and HOLD 1).
module tb_sop_sweep_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, start1 = 1'b0;
  logic pp, qq, rr, ss, busy, done, pass, tt;
  logic pp1, qq1, rr1, ss1, busy1, done1, pass1, tt1;
  logic [15:0] table_out, table1;
  int mode = 0;
  int n = 0, nf = 0;
  int done_cyc, done_cnt, busy_cnt, busy_err, vec_err, rst_err, d1;
`ifdef SOP_SWEEP_FAILCAP_EN
  logic fail_valid, fail_valid1;
  logic [3:0] fail_idx, fail_idx1;
`endif
  always #5 clk = ~clk;
  function automatic logic sop(input logic [3:0] v, input int m);
    logic t;
    t = (v[1] & ~v[0]) | (v[3] & ~v[2] & ~v[1] & v[0]);
    return (m == 1) ? 1'b0 : (t ^ (m == 2 && v == 4'd9));
  endfunction
  assign tt  = sop({pp, qq, rr, ss}, mode);
  assign tt1 = sop({pp1, qq1, rr1, ss1}, mode);
  sop_sweep_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tt(tt),
    .pp(pp), .qq(qq), .rr(rr), .ss(ss), .busy(busy), .done(done), .pass(pass), .table_out(table_out)
`ifdef SOP_SWEEP_FAILCAP_EN
    , .fail_valid(fail_valid), .fail_idx(fail_idx)
`endif
  );
  sop_sweep_ctrl #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .tt(tt1),
    .pp(pp1), .qq(qq1), .rr(rr1), .ss(ss1), .busy(busy1), .done(done1), .pass(pass1), .table_out(table1)
`ifdef SOP_SWEEP_FAILCAP_EN
    , .fail_valid(fail_valid1), .fail_idx(fail_idx1)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sweep(input int abort_at, input int restart_at, input int rst_at);
    logic [3:0] ev;
    logic eb;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; busy_err = 0; vec_err = 0; rst_err = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 340; c++) begin
      start = 1'b0;
      abort = 1'b0;
      eb = (c <= 320) && (abort_at == 0 || c <= abort_at);
      ev = eb ? 4'((c - 1) / 20) : 4'd0;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy) busy_cnt++;
      if (busy !== eb) busy_err++;
      if ({pp, qq, rr, ss} !== ev) vec_err++;
      if (c == abort_at) abort = 1'b1;
      if (c == restart_at) start = 1'b1;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        if ({busy, done, pass, pp, qq, rr, ss} !== 7'd0 || table_out !== 16'h0) rst_err++;
        @(negedge clk);
        if ({busy, done, pass, pp, qq, rr, ss} !== 7'd0 || table_out !== 16'h0) rst_err++;
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_table", 32'(table_out), 0);
    chk("rst_pqrs", 32'({pp, qq, rr, ss}), 0);
    @(negedge clk) rst_n = 1'b1;
    mode = 0;
    sweep(0, 0, 0);
    chk("good_done_cyc", done_cyc, 321);
    chk("good_done_cnt", done_cnt, 1);
    chk("good_busy_cnt", busy_cnt, 320);
    chk("good_busy_err", busy_err, 0);
    chk("good_vec_err", vec_err, 0);
    chk("good_table", 32'(table_out), 32'h4644);
    chk("good_pass", 32'(pass), 1);
    mode = 1;
    sweep(0, 0, 0);
    chk("stuck_done_cyc", done_cyc, 321);
    chk("stuck_table", 32'(table_out), 0);
    chk("stuck_pass", 32'(pass), 0);
`ifdef SOP_SWEEP_FAILCAP_EN
    chk("stuck_fail_valid", 32'(fail_valid), 1);
    chk("stuck_fail_idx", 32'(fail_idx), 2);
`endif
    mode = 2;
    sweep(0, 0, 0);
    chk("inv9_table", 32'(table_out), 32'h4444);
    chk("inv9_pass", 32'(pass), 0);
`ifdef SOP_SWEEP_FAILCAP_EN
    chk("inv9_fail_valid", 32'(fail_valid), 1);
    chk("inv9_fail_idx", 32'(fail_idx), 9);
`endif
    mode = 0;
    sweep(0, 100, 0);
    chk("restart_done_cyc", done_cyc, 321);
    chk("restart_done_cnt", done_cnt, 1);
    chk("restart_vec_err", vec_err, 0);
    chk("restart_table", 32'(table_out), 32'h4644);
    chk("restart_pass", 32'(pass), 1);
`ifdef SOP_SWEEP_FAILCAP_EN
    chk("restart_fail_valid", 32'(fail_valid), 0);
`endif
    sweep(150, 0, 0);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_busy_err", busy_err, 0);
    chk("abort_vec_err", vec_err, 0);
    chk("abort_table", 32'(table_out), 32'h0044);
    chk("abort_pass", 32'(pass), 0);
    sweep(0, 0, 200);
    chk("rst_mid_outputs", rst_err, 0);
    chk("rst_mid_done_cnt", done_cnt, 0);
    sweep(0, 0, 0);
    chk("post_rst_done_cyc", done_cyc, 321);
    chk("post_rst_table", 32'(table_out), 32'h4644);
    chk("post_rst_pass", 32'(pass), 1);
    d1 = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (done1 && d1 == 0) d1 = c;
      @(negedge clk);
    end
    chk("h1_done_cyc", d1, 17);
    chk("h1_table", 32'(table1), 32'h4644);
    chk("h1_pass", 32'(pass1), 1);
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
